// File: rtl/rst_sequencer.sv
// Reset sequencer: drives the low-active per-module reset vector, holding targeted resets for a
// fixed stretch and then releasing them one at a time, lowest index first.
`timescale 1ns/1ps

`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_1B
`define BUS_ACC_1B 2'd0
`endif

module rst_sequencer #(
    parameter int unsigned RST_WIDTH   = 4,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned GAP_CYCLES  = 4,
    parameter int unsigned VA_WIDTH    = 2,
    parameter int unsigned BUS_WIDTH   = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wdt_req,
    output logic [RST_WIDTH-1:0]      rst_ob,
    output logic                      busy,
    input  logic [VA_WIDTH-1:0]       addr,
    input  logic                      w_rb,
    input  logic [`BUS_ACC_WIDTH-1:0] acc,
    output logic [BUS_WIDTH-1:0]      rdata,
    input  logic [BUS_WIDTH-1:0]      wdata,
    input  logic                      req,
    output logic                      resp,
    output logic                      fault
);

    localparam int unsigned CntMax = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

    localparam logic [CntW-1:0]     HoldLoad   = CntW'(HOLD_CYCLES - 1);
    localparam logic [CntW-1:0]     GapLoad    = CntW'(GAP_CYCLES - 1);
    localparam logic [VA_WIDTH-1:0] AddrCtrl   = VA_WIDTH'(0);
    localparam logic [VA_WIDTH-1:0] AddrCause  = VA_WIDTH'(1);
    localparam logic [VA_WIDTH-1:0] AddrStatus = VA_WIDTH'(2);

    typedef enum logic [1:0] {StIdle, StHold, StRelease} state_e;

    state_e               state_q, state_d;
    logic [RST_WIDTH-1:0] tgt_q, tgt_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [2:0]           cause_q, cause_d;
    logic                 resp_q, resp_d;
    logic [BUS_WIDTH-1:0] rdata_q, rdata_d;

    logic                 is_ctrl, is_cause, is_status;
    logic                 bad_acc, bad_addr, bad_dir, bad_ctrl, invld;
    logic                 acc_ok, ctrl_we, cause_we;
    logic [RST_WIDTH-1:0] req_mask;
    logic [BUS_WIDTH-1:0] rd_val;

    // Bus decode and validity
    always_comb begin
        is_ctrl   = (addr == AddrCtrl);
        is_cause  = (addr == AddrCause);
        is_status = (addr == AddrStatus);
        bad_acc   = (acc != `BUS_ACC_1B);
        bad_addr  = ~(is_ctrl | is_cause | is_status);
        bad_dir   = (is_status & w_rb) | (is_ctrl & ~w_rb);
        bad_ctrl  = is_ctrl & w_rb & ((wdata > BUS_WIDTH'(RST_WIDTH)) | busy);
        invld     = bad_acc | bad_addr | bad_dir | bad_ctrl;
        acc_ok    = req & ~invld;
        ctrl_we   = acc_ok & w_rb & is_ctrl;
        cause_we  = acc_ok & w_rb & is_cause;
        fault     = req & invld;
    end

    // CTRL value 0 targets every module, k targets module k-1 only
    always_comb begin
        req_mask = '0;
        if (wdata == '0) begin
            req_mask = '1;
        end else begin
            for (int k = 0; k < RST_WIDTH; k++) begin
                if (wdata == BUS_WIDTH'(k + 1)) begin
                    req_mask[k] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rd_val = '0;
        if (is_cause) begin
            rd_val[2:0] = cause_q;
        end else if (is_status) begin
            rd_val[0] = busy;
        end
        rdata_d = (acc_ok & ~w_rb) ? rd_val : '0;
        resp_d  = acc_ok;
    end

    // Hardware sets take priority over a same-cycle write-1-clear
    always_comb begin
        cause_d = cause_q;
        if (cause_we) begin
            cause_d = cause_q & ~wdata[2:0];
        end
        cause_d[0] = cause_d[0] | ctrl_we;
        cause_d[1] = cause_d[1] | wdt_req;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StHold;
            tgt_q   <= '1;
            cnt_q   <= HoldLoad;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cause_q <= 3'b100;
            resp_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            cause_q <= cause_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
            end
            StHold, StRelease: begin
                if (cnt_q == '0) begin
                    // Clear the lowest set bit of the target mask
                    tgt_d   = tgt_q & (tgt_q - RST_WIDTH'(1));
                    cnt_d   = GapLoad;
                    state_d = (tgt_d == '0) ? StIdle : StRelease;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                tgt_d   = '0;
                cnt_d   = '0;
            end
        endcase
        if (wdt_req) begin
            state_d = StHold;
            tgt_d   = '1;
            cnt_d   = HoldLoad;
        end else if (ctrl_we) begin
            state_d = StHold;
            tgt_d   = req_mask;
            cnt_d   = HoldLoad;
        end
    end

    // Outputs
    always_comb begin
        busy   = (state_q != StIdle);
        rst_ob = (state_q == StIdle) ? '1 : ~tgt_q;
        resp   = resp_q;
        rdata  = rdata_q;
    end

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Bus-programmable reset sequencer that owns the per-module low-active reset vector of the MCU.
- Collects reset requests from three sources: software bus write, watchdog pulse and synchronous system reset.
- Holds the targeted resets asserted for a fixed stretch, then releases the targeted modules one at a time in ascending index order, with a fixed gap between releases.
- Records the reset cause for firmware.

Parameters:
RST_WIDTH, 4, number of module reset lines (1..8)
HOLD_CYCLES, 16, cycles all targeted resets stay asserted (>=1)
GAP_CYCLES, 4, cycles between successive staged releases (>=1)
VA_WIDTH, 2, register address width
BUS_WIDTH, 32, bus data width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
wdt_req  in  1  watchdog reset request pulse; always a full reset
rst_ob  out  RST_WIDTH  module resets, low active, bit k = module k
busy  out  1  sequence in progress
addr  in  VA_WIDTH  register address
w_rb  in  1  1=write, 0=read
acc  in  `BUS_ACC_WIDTH  access size
rdata  out  BUS_WIDTH  read data
wdata  in  BUS_WIDTH  write data
req  in  1  bus request
resp  out  1  bus response, one cycle after valid req
fault  out  1  combinational fault on invalid req

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Register map (all accesses 1 byte):
  - addr 0 CTRL (W):
    - wdata 0 = full reset (target all bits).
    - wdata k, 1..RST_WIDTH = reset module k-1 only.
  - addr 1 CAUSE (R/W1C): bit0 software, bit1 watchdog, bit2 system rst; other bits read 0.
  - addr 2 STATUS (R): bit0 = busy.
  - addr 3: invalid.
- Fault is asserted as req & invld. invld is the OR of:
  - acc != `BUS_ACC_1B;
  - addr 3;
  - write to STATUS, or read of CTRL;
  - CTRL write with wdata > RST_WIDTH;
  - CTRL write while busy.
- Bus response:
  - resp is a register, set to req & ~invld.
  - rdata is registered, zero-extended, valid in the resp cycle, and 0 otherwise.
  - A CAUSE write clears the bits written as 1.
- State machine has three states: IDLE, HOLD, RELEASE. It also keeps a target mask tgt[RST_WIDTH] and a down-counter cnt.
  - IDLE: rst_ob = all 1, busy = 0.
  - Valid CTRL write accepted at cycle T:
    - tgt := the requested mask; state := HOLD; cnt := HOLD_CYCLES-1; CAUSE bit0 set.
    - rst_ob has the targeted bits low from T+1.
  - HOLD:
    - rst_ob = ~tgt.
    - cnt decrements each cycle. At cnt==0, go to RELEASE and deassert (drive high) the lowest set bit of tgt, clearing it from tgt.
    - Targeted bits are therefore low for exactly HOLD_CYCLES cycles.
  - RELEASE:
    - cnt reloads to GAP_CYCLES-1 after each release. At cnt==0, the next lowest set bit of tgt is released.
    - The edge that clears the last tgt bit also enters IDLE.
  - busy = (state != IDLE); it goes 0 in the same cycle the final bit goes high.
- wdt_req = 1 in any state, on the same edge:
  - tgt := all 1; state := HOLD; cnt := HOLD_CYCLES-1; CAUSE bit1 set.
  - A partial reset in progress escalates to a full reset. A full reset in progress restarts its hold.
- wdt_req and a valid CTRL write in the same cycle:
  - The write is still acknowledged with resp.
  - CAUSE sets bits 0 and 1.
  - tgt = all 1 (watchdog wins).
- rst = 1 on an edge:
  - State := HOLD; tgt := all 1; cnt := HOLD_CYCLES-1.
  - rst_ob := 0; busy := 1; resp := 0; rdata := 0; CAUSE := 3'b100.
  - rst overrides wdt_req and bus writes.
  - While rst is held, rst_ob stays 0 and cnt stays reloaded. Release begins HOLD_CYCLES cycles after rst drops.
- The block itself is never reset by rst_ob.
- A CAUSE write-1-clear in the same cycle as a hardware set: the set wins.
- cnt width = clog2(max(HOLD_CYCLES, GAP_CYCLES)). Counters saturate at 0 and never wrap.

Test Plan:
1. Full reset. rst high 2 cycles, then low. Expect:
   - rst_ob = 4'b0000 for 16 cycles after rst drops.
   - Then 0001, 0011, 0111, 1111 at +0/+4/+8/+12 of release.
   - busy falls with 1111; CAUSE reads 0x04.
2. Partial reset. Write CTRL=3 at T. Expect:
   - resp at T+1.
   - rst_ob = 4'b1011 during T+1..T+16; 1111 at T+17.
   - busy 0 at T+17; CAUSE bit0 = 1.
3. Watchdog escalation. Write CTRL=2, then wdt_req pulse at T+5. Expect:
   - rst_ob = 0000 from T+6 for 16 cycles, then staged release.
   - CAUSE = 0x03 after W1C of bit2.
4. Bus faults. Each of the following gives fault = 1, no resp and no state change:
   - CTRL=5;
   - CTRL write while busy;
   - 2-byte access;
   - addr 3;
   - write to STATUS.
5. Collision. CTRL=1 write and wdt_req in the same cycle. Expect resp = 1, full-reset sequence, CAUSE bits 0 and 1 set.
6. Reset mid-RELEASE. Assert rst while rst_ob = 0011. Expect:
   - rst_ob = 0000 on the next edge.
   - The sequence restarts after rst drops.
   - CAUSE = 0x04.
